// File: rtl/shift_seq_pkg.sv
// Shared encodings for the iterative shift sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package shift_seq_pkg;

    // Shift operation encodings as carried on the op input.
    localparam logic [1:0] OP_SLL  = 2'b00;
    localparam logic [1:0] OP_SRL  = 2'b01;
    localparam logic [1:0] OP_SRA  = 2'b10;
    localparam logic [1:0] OP_ROTR = 2'b11;

    // Sequencer control states.
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

endpackage

// File: rtl/shift_step.sv
// One iteration of the shift datapath: moves acc by 2 or by 1 position.
// Latency: combinational.
// Backpressure: none; the sequencer decides when the step is committed.
import shift_seq_pkg::*;

module shift_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] acc,
    input  logic [1:0]       op_q,
    input  logic             by2,
    output logic [WIDTH-1:0] nxt
);

    // Select the fill pattern for the requested operation and step size.
    always_comb begin
        nxt = acc;
        case (op_q)
            OP_SLL:  nxt = by2 ? {acc[WIDTH-3:0], 2'b00} : {acc[WIDTH-2:0], 1'b0};
            OP_SRL:  nxt = by2 ? {2'b00, acc[WIDTH-1:2]} : {1'b0, acc[WIDTH-1:1]};
            OP_SRA:  nxt = by2 ? {{2{acc[WIDTH-1]}}, acc[WIDTH-1:2]}
                               : {acc[WIDTH-1], acc[WIDTH-1:1]};
            OP_ROTR: nxt = by2 ? {acc[1:0], acc[WIDTH-1:2]} : {acc[0], acc[WIDTH-1:1]};
            default: nxt = acc;
        endcase
    end

endmodule

// File: rtl/shift_sequencer.sv
// Iterative shifter: 2-bit steps plus a final 1-bit step for odd amounts.
// Latency: ceil(shamt/2)+1 cycles from accept to the done pulse.
// Backpressure: accepts only when ready; busy stalls the pipeline while shifting.
import shift_seq_pkg::*;

module shift_sequencer #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [1:0]         op,
    input  logic [WIDTH-1:0]   operand,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic               flush,
    output logic               ready,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   result
);

    state_t             state;
    logic [WIDTH-1:0]   acc;
    logic [1:0]         op_q;
    logic [SHAMT_W-1:0] cnt;
    logic [WIDTH-1:0]   step_acc;
    logic               by2;
    logic               accept;

    // Take the wide step whenever at least two positions remain.
    assign by2 = (cnt >= SHAMT_W'(2));

    // A request is only taken in IDLE, and a concurrent flush drops it.
    assign accept = start && (state == IDLE) && !flush;

    shift_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .acc  (acc),
        .op_q (op_q),
        .by2  (by2),
        .nxt  (step_acc)
    );

    // Control FSM, step counter and accumulator; flush aborts without touching acc.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            acc   <= '0;
            op_q  <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        acc   <= operand;
                        op_q  <= op;
                        cnt   <= shamt;
                        state <= (shamt == '0) ? DONE : SHIFT;
                    end
                end
                SHIFT: begin
                    if (flush) begin
                        state <= IDLE;
                    end else begin
                        acc <= step_acc;
                        if (by2) begin
                            cnt   <= cnt - SHAMT_W'(2);
                            state <= (cnt == SHAMT_W'(2)) ? DONE : SHIFT;
                        end else begin
                            cnt   <= '0;
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Status decodes straight from the state register; busy also covers the accept cycle.
    assign ready  = (state == IDLE);
    assign done   = (state == DONE);
    assign busy   = (state == SHIFT) || accept;
    assign result = acc;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer: vector table plus multi-cycle corner cases.
// Latency: n/a.
// Backpressure: n/a.
import shift_seq_pkg::*;

module tb_shift_sequencer;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] operand;
    logic [4:0]  shamt;
    logic        flush;
    logic        ready;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int n_vec;
    int n_bad;

    shift_sequencer #(
        .WIDTH   (32),
        .SHAMT_W (5)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .op      (op),
        .operand (operand),
        .shamt   (shamt),
        .flush   (flush),
        .ready   (ready),
        .busy    (busy),
        .done    (done),
        .result  (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] operand;
        logic [4:0]  shamt;
        logic [31:0] exp_result;
        int          exp_lat;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, got, exp);
        end
    endtask

    // Issue one request and wait (bounded) for done; returns at the done cycle's negedge.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [4:0] s,
                          output int lat, output logic [31:0] res);
        @(negedge clk);
        op = o; operand = a; shamt = s; start = 1'b1;
        #1;
        chk("accept_ready", 32'(ready), 32'd1);
        chk("accept_busy", 32'(busy), 32'd1);
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        res = result;
    endtask

    int          lat;
    int          cnt_done;
    int          cnt_busy;
    logic [31:0] res;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec = 0; n_bad = 0;
        rst = 1'b1; start = 1'b0; flush = 1'b0;
        op = OP_SLL; operand = '0; shamt = '0;

        //              op       operand        shamt  result         latency
        vecs[0] = '{OP_SLL,  32'h0000_0001, 5'd5,  32'h0000_0020, 4};
        vecs[1] = '{OP_SRA,  32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 17};
        vecs[2] = '{OP_ROTR, 32'h0000_0003, 5'd1,  32'h8000_0001, 2};
        vecs[3] = '{OP_SRL,  32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF, 1};
        vecs[4] = '{OP_SRL,  32'h8000_0000, 5'd4,  32'h0800_0000, 3};
        vecs[5] = '{OP_SRA,  32'h7000_0000, 5'd3,  32'h0E00_0000, 3};
        vecs[6] = '{OP_ROTR, 32'h1234_5678, 5'd8,  32'h7812_3456, 5};
        vecs[7] = '{OP_SLL,  32'hFFFF_FFFF, 5'd31, 32'h8000_0000, 17};
        vecs[8] = '{OP_ROTR, 32'h8000_0001, 5'd2,  32'h6000_0000, 2};
        vecs[9] = '{OP_SRA,  32'hF000_000F, 5'd6,  32'hFFC0_0000, 4};

        // Reset state
        #12;
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_result", result, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Table-driven vectors
        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].op, vecs[i].operand, vecs[i].shamt, lat, res);
            chk($sformatf("v%0d_result", i), res, vecs[i].exp_result);
            chk($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
            chk($sformatf("v%0d_busy_in_done", i), 32'(busy), 32'd0);
            @(negedge clk);
            chk($sformatf("v%0d_ready_after", i), 32'(ready), 32'd1);
            chk($sformatf("v%0d_done_single", i), 32'(done), 32'd0);
            chk($sformatf("v%0d_result_held", i), result, vecs[i].exp_result);
        end

        // busy stays high for exactly the three SHIFT cycles of SLL by 5
        @(negedge clk);
        op = OP_SLL; operand = 32'h1; shamt = 5'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cnt_busy = 0;
        for (int c = 0; c < 3; c++) begin
            if (busy) cnt_busy++;
            @(negedge clk);
        end
        chk("busy_cycles", 32'(cnt_busy), 32'd3);
        chk("busy_low_at_done", 32'(busy), 32'd0);
        chk("done_after_busy", 32'(done), 32'd1);

        // start during SHIFT is ignored; start right after done is accepted
        @(negedge clk);
        op = OP_SLL; operand = 32'h1; shamt = 5'd6; start = 1'b1;
        @(negedge clk);
        op = OP_SRL; operand = 32'h0000_FFFF; shamt = 5'd0; start = 1'b1;
        #1;
        chk("ign_ready_low", 32'(ready), 32'd0);
        lat = 1;
        @(negedge clk);
        start = 1'b0;
        lat = 2;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("ign_latency", 32'(lat), 32'd4);
        chk("ign_result", result, 32'h0000_0040);
        run_op(OP_ROTR, 32'h0000_000F, 5'd4, lat, res);
        chk("b2b_latency", 32'(lat), 32'd3);
        chk("b2b_result", res, 32'hF000_0000);

        // flush two cycles into SLL by 10: back to IDLE, acc keeps the one completed step
        @(negedge clk);
        @(negedge clk);
        op = OP_SLL; operand = 32'h1; shamt = 5'd10; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_ready", 32'(ready), 32'd1);
        chk("flush_done", 32'(done), 32'd0);
        chk("flush_busy", 32'(busy), 32'd0);
        chk("flush_acc", result, 32'h0000_0004);
        cnt_done = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (done) cnt_done++;
        end
        chk("flush_no_done", 32'(cnt_done), 32'd0);

        // flush together with start in IDLE drops the request
        op = OP_SRL; operand = 32'hAAAA_5555; shamt = 5'd3; start = 1'b1; flush = 1'b1;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        chk("fs_ready", 32'(ready), 32'd1);
        chk("fs_result", result, 32'h0000_0004);
        cnt_done = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (done) cnt_done++;
        end
        chk("fs_no_done", 32'(cnt_done), 32'd0);

        // asynchronous reset mid-SHIFT, between clock edges
        op = OP_SRA; operand = 32'h8000_0000; shamt = 5'd31; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_busy", 32'(busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("arst_ready", 32'(ready), 32'd1);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        chk("arst_result", result, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        cnt_done = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (done) cnt_done++;
        end
        chk("arst_no_done", 32'(cnt_done), 32'd0);
        chk("arst_ready_after", 32'(ready), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/shift_sequencer.md
# shift_sequencer

Multi-cycle shift unit for the EX stage. It accepts one shift instruction (SLL, SRL, SRA, ROTR) and applies it using a fixed 2-bit shift step, plus a 1-bit step for odd amounts. It holds the pipeline via `busy` until the result is ready. It replaces a full 32-bit barrel shifter with a small iterative datapath and the control that sequences it.

## Interface
Parameters:
- `WIDTH`, 32, operand/result width
- `SHAMT_W`, 5, shift-amount width

Ports:
- `clk`  in  1  clock; all state updates on the rising edge
- `rst`  in  1  asynchronous, active-high reset
- `start`  in  1  request; accepted only when `ready`=1
- `op`  in  2  00 SLL, 01 SRL, 10 SRA, 11 ROTR (rotate right)
- `operand`  in  WIDTH  value to shift; sampled on accept
- `shamt`  in  SHAMT_W  shift amount; sampled on accept
- `flush`  in  1  synchronous abort from the hazard/branch logic
- `ready`  out  1  high only in IDLE
- `busy`  out  1  high in SHIFT and on the accept cycle (`start & ready`); drives the pipeline stall
- `done`  out  1  single-cycle pulse; `result` is valid
- `result`  out  WIDTH  shifted value; held until the next accept

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE:
  - On `start`, latch `operand` into `acc`, `op` into `op_q`, and `shamt` into `cnt`.
  - Next state is DONE if `shamt`=0, else SHIFT.
  - `start` while not in IDLE is ignored; no queueing.
- SHIFT, each cycle:
  - If `cnt`≥2: shift `acc` by 2 and set `cnt` to `cnt`-2.
  - Else: shift `acc` by 1 and set `cnt` to 0.
  - When the new `cnt`=0, next state is DONE.
- Step semantics:
  - SLL fills with zeros on the right.
  - SRL fills with zeros on the left.
  - SRA fills with copies of `acc[WIDTH-1]`.
  - ROTR moves low bits into the high positions.
- DONE: `done`=1 for exactly one cycle, then the state returns to IDLE.
- `result` = `acc`.
- `flush` (any state except IDLE with `start`):
  - Next state is IDLE.
  - No `done` pulse.
  - `acc` is unchanged.
  - `flush` takes priority over the step and over the DONE→IDLE transition.
- `flush` and `start` together in IDLE: `flush` wins and the request is dropped.
- Reset values:
  - state IDLE
  - `acc`=0, `cnt`=0, `op_q`=0
  - `ready`=1, `busy`=0, `done`=0, `result`=0
- Reset mid-operation returns to these values immediately; no `done`.

## Timing
- Accepting edge E0. SHIFT steps occur at edges E1..Ek, with k = ceil(`shamt`/2).
- `done` is high in the cycle after edge E(k+... ) as follows:
  - `shamt`=0: `done` high in the cycle after E0 (latency 1).
  - `shamt`=31: k=16, `done` in the cycle after E16 (latency 17).
  - General latency is ceil(`shamt`/2)+1 cycles from accept to `done`.
- `ready` returns high in the cycle after `done`.
- Back-to-back accept period = latency + 1 cycles.
- `busy` is low in the DONE cycle, so the dependent instruction advances with `result` valid.
- `result` is stable from `done` until the next accepting edge.

## Structure
- Package `shift_seq_pkg` holds:
  - op encodings `OP_SLL`, `OP_SRL`, `OP_SRA`, `OP_ROTR`
  - the state enum (IDLE/SHIFT/DONE)
- Sub-module `shift_step`: combinational, inputs `acc`, `op_q`, and a 1-bit `by2` select; output is the next `acc`. It contains the 2-bit and 1-bit shift datapath.
- The FSM, counter, and registers live in `shift_sequencer`.

## Test plan
- SLL: `operand`=0x0000_0001, `shamt`=5 → `done` 4 cycles after accept; `result`=0x0000_0020; `busy` high 3 cycles.
- SRA: `operand`=0x8000_0000, `shamt`=31 → `done` 17 cycles after accept; `result`=0xFFFF_FFFF.
- ROTR: `operand`=0x0000_0003, `shamt`=1 → `result`=0x8000_0001 after 2 cycles. SRL with `shamt`=0 on 0xDEAD_BEEF → `result`=0xDEAD_BEEF, `done` in the next cycle.
- `start` pulsed during SHIFT with a different operand → ignored; the first result completes unchanged. New `start` in the cycle after `done` is accepted.
- `flush` asserted 2 cycles into SLL `shamt`=10 → IDLE next cycle, no `done`, `ready`=1. `flush` together with `start` in IDLE → no accept.
- `rst` asserted mid-SHIFT, asynchronously between edges → outputs go immediately to `ready`=1, `busy`=0, `done`=0, `result`=0.
